// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment types and the hex-to-segment table for the scan controller
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low {g,f,e,d,c,b,a} pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scanner with frame snapshots, event overlay, blanking and PWM
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_LOG2   = 18,
  parameter int DIM_BITS    = 4,
  parameter int HOLD_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] live_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  input  logic [DIM_BITS-1:0]     bright,
  input  logic                    ev_valid,
  input  logic [4*NUM_DIGITS-1:0] ev_data,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick,
  output logic                    overlay_active
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

  logic [SLOT_LOG2-1:0]    pcnt;
  logic [IW-1:0]           idx;
  logic [HW-1:0]           hold_cnt;
  logic [4*NUM_DIGITS-1:0] snap, ev_reg;
  logic [NUM_DIGITS-1:0]   dp_snap, lead, blank;
  logic                    lz_snap;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic                    slot_end, frame_edge, hold_on, lit;

  assign slot_end   = &pcnt;
  assign frame_edge = slot_end && (idx == LAST);
  assign hold_on    = hold_cnt != '0;
  assign lit        = pcnt[SLOT_LOG2-1 -: DIM_BITS] <= bright;
  assign nib        = snap[4*idx +: 4];
  assign blank      = lz_snap ? {lead[NUM_DIGITS-1:1], 1'b0} : '0;

  seg7_decode u_dec (
    .nib (nib),
    .seg (dec)
  );

  // lead[k]: this digit and every digit to its left are zero in the snapshot
  always_comb begin
    lead = '0;
    for (int k = 0; k < NUM_DIGITS; k++) lead[k] = (snap >> (4*k)) == '0;
  end

  // slot counter and digit index; frame_tick marks the cycle after the wrap to digit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= pcnt + 1'b1;
      frame_tick <= frame_edge;
      if (slot_end) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // event capture and frame-coherent snapshot; an event load always beats the frame decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt       <= '0;
      ev_reg         <= '0;
      snap           <= '0;
      dp_snap        <= '0;
      lz_snap        <= 1'b0;
      overlay_active <= 1'b0;
    end else begin
      overlay_active <= hold_on;
      if (frame_edge) begin
        snap    <= hold_on ? ev_reg : live_data;
        dp_snap <= dp_mask;
        lz_snap <= lz_en;
      end
      if (ev_valid) begin
        ev_reg   <= ev_data;
        hold_cnt <= HOLD_INIT;
      end else if (frame_edge && hold_on) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // registered drive: one active-low anode per lit slot, everything dark while PWM is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg <= (lit && !blank[idx]) ? dec : SEG_BLANK;
      dp  <= lit ? ~dp_snap[idx] : 1'b1;
    end
  end
endmodule
